// File: rtl/uart_pkg.sv
// Shared UART register map and the TX arbiter state encoding. The UART core
// imports the same package, so the register offsets cannot drift apart.
package uart_pkg;

  // Register offsets relative to the UART base address
  localparam logic [31:0] UartRxOffset     = 32'h0000_0000;
  localparam logic [31:0] UartTxOffset     = 32'h0000_0004;
  localparam logic [31:0] UartStatusOffset = 32'h0000_0008;

  // Bit positions inside the status register
  localparam int StatusRxEmptyBit = 0;
  localparam int StatusTxFullBit  = 1;

  // Per-byte transfer sequence of the TX arbiter
  typedef enum logic [2:0] {
    ARB       = 3'd0,
    STAT_REQ  = 3'd1,
    STAT_WAIT = 3'd2,
    BACKOFF   = 3'd3,
    WR_REQ    = 3'd4,
    WR_WAIT   = 3'd5
  } uart_arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the first asserted valid bit at or after
// ptr_i, wrapping modulo NumReq. Returns the pick as one-hot and as an index.
module rr_arbiter #(
  parameter int NumReq = 2,
  localparam int IdxW = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic [NumReq-1:0] valid_i,
  input  logic [IdxW-1:0]   ptr_i,
  output logic [NumReq-1:0] grant_o,
  output logic [IdxW-1:0]   idx_o,
  output logic              any_o
);

  int              sum_s;
  int              cand_s;
  logic [IdxW-1:0] cand_idx_s;

  // Scan from the farthest candidate to the nearest so the nearest valid wins
  always_comb begin
    grant_o    = '0;
    idx_o      = '0;
    any_o      = 1'b0;
    sum_s      = 0;
    cand_s     = 0;
    cand_idx_s = '0;
    for (int k = NumReq - 1; k >= 0; k--) begin
      sum_s      = int'(ptr_i) + k;
      cand_s     = (sum_s >= NumReq) ? (sum_s - NumReq) : sum_s;
      cand_idx_s = cand_s[IdxW-1:0];
      if (valid_i[cand_idx_s]) begin
        grant_o             = '0;
        grant_o[cand_idx_s] = 1'b1;
        idx_o               = cand_idx_s;
        any_o               = 1'b1;
      end else begin
        any_o = any_o;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between NumReq byte-stream requesters. Grants
// are round-robin and locked for a whole packet; each byte is written to the
// TX register only after a status read shows room in the TX FIFO.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int                   NumReq       = 2,
  parameter int                   AddrWidth    = 32,
  parameter int                   DataWidth    = 32,
  parameter logic [AddrWidth-1:0] UartBase     = 32'h8000_1000,
  parameter int                   PollInterval = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [NumReq-1:0]          req_valid_i,
  input  logic [NumReq*8-1:0]        req_data_i,
  input  logic [NumReq-1:0]          req_last_i,
  output logic [NumReq-1:0]          req_ready_o,
  output logic                       host_req_o,
  output logic [AddrWidth-1:0]       host_addr_o,
  output logic                       host_we_o,
  output logic [3:0]                 host_be_o,
  output logic [DataWidth-1:0]       host_wdata_o,
  input  logic                       host_rvalid_i,
  input  logic [DataWidth-1:0]       host_rdata_i,
  output logic                       busy_o,
  output logic [$clog2(NumReq)-1:0]  grant_o
);

  localparam int IdxW = $clog2(NumReq);
  localparam int CntW = (PollInterval > 1) ? $clog2(PollInterval) : 1;

  uart_arb_state_t      state_q, state_d;
  logic [IdxW-1:0]      rr_q, rr_d;
  logic [IdxW-1:0]      grant_q, grant_d;
  logic                 lock_q, lock_d;
  logic [7:0]           byte_q, byte_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic                 host_req_q, host_req_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic                 we_q, we_d;
  logic [DataWidth-1:0] wdata_q, wdata_d;
  logic                 busy_q, busy_d;

  logic [NumReq-1:0]    own_mask_s;
  logic [NumReq-1:0]    elig_s;
  logic [IdxW-1:0]      ptr_s;
  logic [NumReq-1:0]    arb_grant_s;
  logic [IdxW-1:0]      arb_idx_s;
  logic                 arb_any_s;
  logic                 rdata_unused_s;

  // While a packet is open only its owner is eligible; otherwise everyone is
  assign own_mask_s = {{(NumReq-1){1'b0}}, 1'b1} << grant_q;
  assign elig_s     = lock_q ? (req_valid_i & own_mask_s) : req_valid_i;
  assign ptr_s      = lock_q ? grant_q : rr_q;

  rr_arbiter #(.NumReq(NumReq)) u_rr (
    .valid_i (elig_s),
    .ptr_i   (ptr_s),
    .grant_o (arb_grant_s),
    .idx_o   (arb_idx_s),
    .any_o   (arb_any_s)
  );

  // The ready pulse must coincide with the cycle the byte is sampled
  assign req_ready_o    = (state_q == ARB) ? arb_grant_s : '0;
  assign host_be_o      = 4'b0001;
  assign host_req_o     = host_req_q;
  assign host_addr_o    = addr_q;
  assign host_we_o      = we_q;
  assign host_wdata_o   = wdata_q;
  assign busy_o         = busy_q;
  assign grant_o        = grant_q;
  assign rdata_unused_s = ^host_rdata_i;

  // Next-state, arbitration bookkeeping and registered bus-output values
  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    grant_d    = grant_q;
    lock_d     = lock_q;
    byte_d     = byte_q;
    cnt_d      = cnt_q;
    case (state_q)
      ARB: begin
        if (arb_any_s) begin
          byte_d  = req_data_i[{arb_idx_s, 3'b000} +: 8];
          grant_d = arb_idx_s;
          if (req_last_i[arb_idx_s]) begin
            lock_d = 1'b0;
            rr_d   = (arb_idx_s == IdxW'(NumReq - 1)) ? '0 : arb_idx_s + IdxW'(1);
          end else begin
            lock_d = 1'b1;
          end
          state_d = STAT_REQ;
        end else begin
          state_d = ARB;
        end
      end
      STAT_REQ:  state_d = STAT_WAIT;
      STAT_WAIT: begin
        if (host_rvalid_i) begin
          if (host_rdata_i[StatusTxFullBit]) begin
            cnt_d   = CntW'(PollInterval - 1);
            state_d = BACKOFF;
          end else begin
            state_d = WR_REQ;
          end
        end else begin
          state_d = STAT_WAIT;
        end
      end
      BACKOFF: begin
        if (cnt_q == '0) begin
          state_d = STAT_REQ;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      WR_REQ:  state_d = WR_WAIT;
      WR_WAIT: begin
        if (host_rvalid_i) begin
          state_d = ARB;
        end else begin
          state_d = WR_WAIT;
        end
      end
      default: state_d = ARB;
    endcase

    host_req_d = 1'b0;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    if (state_d == STAT_REQ) begin
      host_req_d = 1'b1;
      we_d       = 1'b0;
      addr_d     = UartBase + AddrWidth'(UartStatusOffset);
    end else if (state_d == WR_REQ) begin
      host_req_d = 1'b1;
      we_d       = 1'b1;
      addr_d     = UartBase + AddrWidth'(UartTxOffset);
      wdata_d    = DataWidth'(byte_d);
    end else begin
      host_req_d = 1'b0;
    end
    busy_d = (state_d != ARB);
  end

  // State and output registers; reset drops any pending byte and the lock
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ARB;
      rr_q       <= '0;
      grant_q    <= '0;
      lock_q     <= 1'b0;
      byte_q     <= 8'h00;
      cnt_q      <= '0;
      host_req_q <= 1'b0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      grant_q    <= grant_d;
      lock_q     <= lock_d;
      byte_q     <= byte_d;
      cnt_q      <= cnt_d;
      host_req_q <= host_req_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      busy_q     <= busy_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus a random
// phase, with a UART device model and a packet-level arbitration model.
module tb_uart_tx_arbiter;

  localparam int          NumReq = 2;
  localparam int          PI     = 16;
  localparam logic [31:0] Base   = 32'h8000_1000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [1:0]  req_valid;
  logic [15:0] req_data;
  logic [1:0]  req_last;
  logic [1:0]  req_ready;
  logic        host_req;
  logic [31:0] host_addr;
  logic        host_we;
  logic [3:0]  host_be;
  logic [31:0] host_wdata;
  logic        host_rvalid;
  logic [31:0] host_rdata;
  logic        busy;
  logic [0:0]  grant;

  uart_tx_arbiter #(
    .NumReq(NumReq), .AddrWidth(32), .DataWidth(32),
    .UartBase(Base), .PollInterval(PI)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_data_i(req_data), .req_last_i(req_last),
    .req_ready_o(req_ready),
    .host_req_o(host_req), .host_addr_o(host_addr), .host_we_o(host_we),
    .host_be_o(host_be), .host_wdata_o(host_wdata),
    .host_rvalid_i(host_rvalid), .host_rdata_i(host_rdata),
    .busy_o(busy), .grant_o(grant)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- UART device model ----------------
  bit          full_q[$];
  bit          rand_mode = 1'b0;
  bit          last_full = 1'b0;
  logic        pend = 1'b0;
  logic [31:0] pend_data = 32'h0;

  initial begin
    bit f;
    host_rvalid = 1'b0;
    host_rdata  = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      host_rvalid = pend;
      host_rdata  = pend_data;
      // Stray response while no access is outstanding: must be ignored
      if (!pend && rand_mode && $urandom_range(0, 9) == 0) begin
        host_rvalid = 1'b1;
        host_rdata  = 32'h0000_0002;
      end
      pend = host_req;
      if (host_req && !host_we) begin
        if (full_q.size() > 0) f = full_q.pop_front();
        else f = rand_mode && ($urandom_range(0, 3) == 0);
        last_full = f;
        pend_data = {30'b0, f, 1'b0};
      end else begin
        pend_data = rand_mode ? 32'($urandom) : 32'h0;
      end
    end
  end

  // ---------------- requester drivers ----------------
  logic [8:0] src0[$];
  logic [8:0] src1[$];
  bit         gap_mode = 1'b0;

  initial begin
    req_valid = 2'b00;
    req_data  = 16'h0;
    req_last  = 2'b00;
    forever begin
      @(posedge clk);
      #1;
      if (src0.size() > 0) begin
        req_valid[0]   = !(gap_mode && $urandom_range(0, 3) == 0);
        req_data[7:0]  = src0[0][7:0];
        req_last[0]    = src0[0][8];
      end else begin
        req_valid[0]   = 1'b0;
        req_data[7:0]  = 8'($urandom);
        req_last[0]    = 1'b0;
      end
      if (src1.size() > 0) begin
        req_valid[1]   = !(gap_mode && $urandom_range(0, 3) == 0);
        req_data[15:8] = src1[0][7:0];
        req_last[1]    = src1[0][8];
      end else begin
        req_valid[1]   = 1'b0;
        req_data[15:8] = 8'($urandom);
        req_last[1]    = 1'b0;
      end
    end
  end

  // ---------------- monitor and reference model ----------------
  typedef struct { int cyc; bit we; logic [31:0] addr; logic [31:0] wdata; } hev_t;
  typedef struct { int cyc; int idx; logic [7:0] b; bit last; } aev_t;
  hev_t       hlog[$];
  aev_t       alog[$];
  logic [7:0] exp_wr[$];
  int         m_rr = 0;
  int         m_lock = -1;
  bit         prev_acc = 1'b0;
  int         prev_idx = 0;

  initial begin
    int a_idx, e_idx, j;
    logic [7:0] a_byte;
    bit a_last;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_acc = 1'b0;
      end else begin
        if (prev_acc) check("grant_o_after_accept", 64'(grant), 64'(prev_idx));
        prev_acc = 1'b0;
        if (req_ready != 2'b00) begin
          check("ready_onehot", 64'($countones(req_ready)), 64'd1);
          a_idx = req_ready[1] ? 1 : 0;
          check("ready_with_valid", 64'(req_valid[a_idx]), 64'd1);
          // Packet owner if a packet is open, else first valid from the pointer
          e_idx = -1;
          if (m_lock >= 0) e_idx = m_lock;
          else begin
            for (int k = NumReq - 1; k >= 0; k--) begin
              j = (m_rr + k) % NumReq;
              if (req_valid[j]) e_idx = j;
            end
          end
          check("rr_pick", 64'(a_idx), 64'(e_idx));
          a_byte = req_data[a_idx*8 +: 8];
          a_last = req_last[a_idx];
          alog.push_back('{cyc, a_idx, a_byte, a_last});
          exp_wr.push_back(a_byte);
          if (a_last) begin
            m_lock = -1;
            m_rr   = (a_idx + 1) % NumReq;
          end else begin
            m_lock = a_idx;
          end
          prev_acc = 1'b1;
          prev_idx = a_idx;
          if (a_idx == 0 && src0.size() > 0) void'(src0.pop_front());
          if (a_idx == 1 && src1.size() > 0) void'(src1.pop_front());
        end
        if (host_req) begin
          hlog.push_back('{cyc, host_we, host_addr, host_wdata});
          check("host_be", 64'(host_be), 64'h1);
          if (host_we) begin
            check("wr_addr", 64'(host_addr), 64'(Base + 32'h4));
            check("wr_only_when_not_full", 64'(last_full), 64'd0);
            check("wr_has_pending_byte", 64'(exp_wr.size() > 0), 64'd1);
            if (exp_wr.size() > 0) check("wr_data", 64'(host_wdata), 64'({24'h0, exp_wr.pop_front()}));
          end else begin
            check("stat_addr", 64'(host_addr), 64'(Base + 32'h8));
          end
        end
      end
    end
  end

  // ---------------- helpers ----------------
  function automatic int nwrites();
    int n = 0;
    foreach (hlog[k]) if (hlog[k].we) n++;
    return n;
  endfunction

  function automatic logic [31:0] wr_data(int n);
    int c = 0;
    logic [31:0] d = 32'hFFFF_FFFF;
    foreach (hlog[k]) begin
      if (hlog[k].we) begin
        if (c == n) d = hlog[k].wdata;
        c++;
      end
    end
    return d;
  endfunction

  task automatic goto_cyc(int c);
    while (cyc < c) begin @(negedge clk); #1; end
  endtask

  task automatic wait_writes(int n, int budget, string tag);
    int k = 0;
    while (nwrites() < n && k < budget) begin @(negedge clk); #1; k++; end
    check(tag, 64'(nwrites() >= n), 64'd1);
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    src0.delete(); src1.delete(); full_q.delete();
    exp_wr.delete(); alog.delete(); hlog.delete();
    m_rr = 0; m_lock = -1;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk); #1;
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_ready"},  64'(req_ready),  64'd0);
    check({tag, "_req"},    64'(host_req),   64'd0);
    check({tag, "_addr"},   64'(host_addr),  64'd0);
    check({tag, "_we"},     64'(host_we),    64'd0);
    check({tag, "_wdata"},  64'(host_wdata), 64'd0);
    check({tag, "_be"},     64'(host_be),    64'h1);
    check({tag, "_busy"},   64'(busy),       64'd0);
    check({tag, "_grant"},  64'(grant),      64'd0);
  endtask

  // ---------------- directed and random sequence ----------------
  initial begin
    int t, s, k, cnt;
    int stat_cyc[$];
    logic [7:0] rr_exp [6];

    // Reset state
    #3 rst_n = 1'b0;
    #1 check_reset_outputs("reset");
    do_reset();

    // Single byte, FIFO not full: exact cycle positions
    src0.push_back({1'b1, 8'h41});
    wait_writes(1, 30, "single_timeout");
    t = alog[0].cyc;
    check("single_stat_cyc",  64'(hlog[0].cyc), 64'(t + 1));
    check("single_stat_we",   64'(hlog[0].we),  64'd0);
    check("single_wr_cyc",    64'(hlog[1].cyc), 64'(t + 3));
    check("single_wr_data",   64'(hlog[1].wdata), 64'h41);
    goto_cyc(t + 4);
    check("single_busy_t4", 64'(busy), 64'd1);
    goto_cyc(t + 5);
    check("single_busy_t5", 64'(busy), 64'd0);
    check("single_one_ready", 64'(alog.size()), 64'd1);

    // Round robin with both requesters always valid
    do_reset();
    for (int i = 0; i < 3; i++) begin
      src0.push_back({1'b1, 8'hA0});
      src1.push_back({1'b1, 8'hB0});
    end
    wait_writes(6, 200, "rr_timeout");
    for (int i = 0; i < 6; i++) begin
      rr_exp[i] = (i % 2 == 0) ? 8'hA0 : 8'hB0;
      check("rr_write_order", 64'(wr_data(i)), 64'({24'h0, rr_exp[i]}));
      check("rr_grant_alternates", 64'(alog[i].idx), 64'(i % 2));
    end

    // Packet lock: requester 1 sends "HI" with a stall between the bytes
    do_reset();
    src0.push_back({1'b1, 8'h30});
    wait_writes(1, 30, "lock_prime_timeout");
    goto_cyc(alog[0].cyc + 5);
    src1.push_back({1'b0, 8'h48});
    src0.push_back({1'b1, 8'h5A});
    wait_writes(2, 30, "lock_h_timeout");
    goto_cyc(cyc + 20);
    check("lock_no_grant_to_other", 64'(alog.size()), 64'd2);
    src1.push_back({1'b1, 8'h49});
    wait_writes(4, 60, "lock_rest_timeout");
    check("lock_order_h", 64'(wr_data(1)), 64'h48);
    check("lock_order_i", 64'(wr_data(2)), 64'h49);
    check("lock_order_z", 64'(wr_data(3)), 64'h5A);

    // Backpressure: three full status reads, then room
    do_reset();
    full_q.push_back(1'b1); full_q.push_back(1'b1); full_q.push_back(1'b1);
    src0.push_back({1'b1, 8'h55});
    wait_writes(1, 300, "bp_timeout");
    goto_cyc(cyc + 10);
    foreach (hlog[i]) if (!hlog[i].we) stat_cyc.push_back(hlog[i].cyc);
    check("bp_stat_count", 64'(stat_cyc.size()), 64'd4);
    // Poll period: STAT_REQ, STAT_WAIT, then PI back-off cycles
    for (int i = 1; i < stat_cyc.size(); i++)
      check("bp_poll_period", 64'(stat_cyc[i] - stat_cyc[i-1]), 64'(PI + 2));
    check("bp_one_write", 64'(nwrites()), 64'd1);
    check("bp_one_ready", 64'(alog.size()), 64'd1);
    if (stat_cyc.size() == 4)
      check("bp_wr_after_stat", 64'(hlog[hlog.size()-1].cyc), 64'(stat_cyc[3] + 2));

    // Reset while in back-off, mid-packet of requester 1
    do_reset();
    src0.push_back({1'b1, 8'h11});
    wait_writes(1, 30, "mid_prime_timeout");
    goto_cyc(alog[0].cyc + 5);
    full_q.push_back(1'b1);
    src1.push_back({1'b0, 8'h50});
    k = 0;
    while (hlog.size() < 3 && k < 40) begin @(negedge clk); #1; k++; end
    check("mid_stat_seen", 64'(hlog.size() >= 3), 64'd1);
    s = hlog[hlog.size()-1].cyc;
    goto_cyc(s + 4);
    check("mid_busy_before", 64'(busy), 64'd1);
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("mid_reset");
    do_reset();
    src1.push_back({1'b1, 8'h53});
    src0.push_back({1'b1, 8'h52});
    wait_writes(2, 60, "mid_after_timeout");
    goto_cyc(cyc + 20);
    check("mid_first_grant", 64'(alog[0].idx), 64'd0);
    check("mid_wr0", 64'(wr_data(0)), 64'h52);
    check("mid_wr1", 64'(wr_data(1)), 64'h53);
    check("mid_no_stale_write", 64'(nwrites()), 64'd2);

    // Random packets, random gaps, random FIFO-full responses
    do_reset();
    rand_mode = 1'b1;
    gap_mode  = 1'b1;
    for (int r = 0; r < 2; r++) begin
      cnt = 0;
      while (cnt < 30) begin
        t = $urandom_range(1, 4);
        for (int b = 0; b < t && cnt < 30; b++) begin
          if (r == 0) src0.push_back({(b == t - 1) || (cnt == 29), 8'($urandom)});
          else        src1.push_back({(b == t - 1) || (cnt == 29), 8'($urandom)});
          cnt++;
        end
      end
    end
    k = 0;
    while (!(src0.size() == 0 && src1.size() == 0 && exp_wr.size() == 0 && !busy) && k < 20000) begin
      @(negedge clk); #1; k++;
    end
    check("rand_drained", 64'(k < 20000), 64'd1);
    check("rand_accepts", 64'(alog.size()), 64'd60);
    check("rand_writes", 64'(nwrites()), 64'd60);
    rand_mode = 1'b0;
    gap_mode  = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
